// File: rtl/sync_gray_ptr.sv
// sync_gray_ptr
//   Multi-stage synchroniser for a Gray-coded FIFO pointer entering the Clk
//   domain. The synchronised Gray value is converted to binary and registered.
//   upd pulses when the pointer moves. Each change between consecutive
//   synchronised samples is checked against the Gray invariant (at most one
//   bit may change). A violation raises err, sets err_sticky and bumps a
//   saturating counter. The pointer still follows the sampled value.
//
// Ports
//   Clk        destination-domain clock, rising edge
//   reset      asynchronous active-high reset
//   In         Gray pointer from the source domain (asynchronous to Clk)
//   err_clr    synchronous clear of err_sticky / err_cnt
//   Out_gray   synchronised Gray pointer (last sync stage)
//   Out_bin    registered binary form of Out_gray
//   upd        1-cycle pulse, Out_bin changed this cycle
//   err        1-cycle pulse, multi-bit jump seen this cycle
//   err_sticky latched violation flag
//   err_cnt    saturating violation count
module sync_gray_ptr #(
    parameter int             N         = 4,
    parameter int             STAGES    = 2,
    parameter logic [N-1:0]   RESET_VAL = '0,
    parameter int             ERR_W     = 4
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [N-1:0]     In,
    input  logic             err_clr,
    output logic [N-1:0]     Out_gray,
    output logic [N-1:0]     Out_bin,
    output logic             upd,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_gray_ptr: STAGES must be >= 2");
        end
    endgenerate

    localparam logic [ERR_W-1:0] CNT_MAX = '1;

    function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // s[0] samples In directly; there is deliberately no input flop.
    logic [STAGES-1:0][N-1:0] s;
    logic [N-1:0]             g_q;
    logic [N-1:0]             diff;
    logic [N-1:0]             diff_m1;
    logic                     changed;
    logic                     multi;

    assign Out_gray = s[STAGES-1];

    // x & (x-1) clears the lowest set bit; anything left means >1 bit flipped.
    always_comb begin
        diff    = Out_gray ^ g_q;
        diff_m1 = diff - N'(1);
        changed = |diff;
        multi   = |(diff & diff_m1);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            s       <= {STAGES{RESET_VAL}};
            g_q     <= RESET_VAL;
            Out_bin <= gray2bin(RESET_VAL);
            upd     <= 1'b0;
            err     <= 1'b0;
        end else begin
            s       <= {s[STAGES-2:0], In};
            g_q     <= Out_gray;
            Out_bin <= gray2bin(Out_gray);
            upd     <= changed;
            err     <= multi;
        end
    end

    // Bookkeeping follows the registered err pulse. A clear coinciding with a
    // pulse keeps that pulse: sticky stays set and the count restarts at 1.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            if (err)          err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;

            if (err_clr)                    err_cnt <= err ? ERR_W'(1) : '0;
            else if (err && err_cnt != CNT_MAX) err_cnt <= err_cnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_sync_gray_ptr.sv
module tb_sync_gray_ptr;

    logic Clk = 1'b0;
    logic reset = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Instance A: defaults (N=4, STAGES=2, ERR_W=4)
    logic [3:0] a_in = 4'h0;
    logic       a_clr = 1'b0;
    logic [3:0] a_og, a_ob;
    logic       a_upd, a_err, a_stk;
    logic [3:0] a_cnt;

    sync_gray_ptr #(.N(4), .STAGES(2), .RESET_VAL(4'h0), .ERR_W(4)) dut (
        .Clk(Clk), .reset(reset), .In(a_in), .err_clr(a_clr),
        .Out_gray(a_og), .Out_bin(a_ob), .upd(a_upd), .err(a_err),
        .err_sticky(a_stk), .err_cnt(a_cnt)
    );

    // Instance E: ERR_W=2 for saturation
    logic [3:0] e_in = 4'h0;
    logic       e_clr = 1'b0;
    logic [3:0] e_og, e_ob;
    logic       e_upd, e_err, e_stk;
    logic [1:0] e_cnt;

    sync_gray_ptr #(.N(4), .STAGES(2), .RESET_VAL(4'h0), .ERR_W(2)) dut_e (
        .Clk(Clk), .reset(reset), .In(e_in), .err_clr(e_clr),
        .Out_gray(e_og), .Out_bin(e_ob), .upd(e_upd), .err(e_err),
        .err_sticky(e_stk), .err_cnt(e_cnt)
    );

    // Instance S: STAGES=3
    logic [3:0] s_in = 4'h0;
    logic       s_clr = 1'b0;
    logic [3:0] s_og, s_ob;
    logic       s_upd, s_err, s_stk;
    logic [3:0] s_cnt;

    sync_gray_ptr #(.N(4), .STAGES(3), .RESET_VAL(4'h0), .ERR_W(4)) dut_s3 (
        .Clk(Clk), .reset(reset), .In(s_in), .err_clr(s_clr),
        .Out_gray(s_og), .Out_bin(s_ob), .upd(s_upd), .err(s_err),
        .err_sticky(s_stk), .err_cnt(s_cnt)
    );

    // Gray code for 0..15
    logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        a_in = 4'h0; e_in = 4'h0; s_in = 4'h0;
        a_clr = 1'b0; e_clr = 1'b0; s_clr = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        a_in = 4'hF;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (a_og !== 4'h0) begin failures++; $display("FAIL reset_og got=%h exp=0", a_og); end
        checks++;
        if (a_ob !== 4'h0) begin failures++; $display("FAIL reset_ob got=%h exp=0", a_ob); end
        checks++;
        if ({a_upd, a_err, a_stk} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b exp=000", {a_upd, a_err, a_stk});
        end
        checks++;
        if (a_cnt !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", a_cnt); end
        tick();
        tick();
        a_in = 4'h0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        do_reset();
        a_in = 4'h1;           // stable before edge k
        tick();                // edge k
        tick();                // edge k+1
        checks++;
        if (a_og !== 4'h1) begin failures++; $display("FAIL lat_og got=%h exp=1", a_og); end
        checks++;
        if (a_ob !== 4'h0) begin failures++; $display("FAIL lat_ob_early got=%h exp=0", a_ob); end
        tick();                // edge k+2
        checks++;
        if (a_ob !== 4'h1 || a_upd !== 1'b1) begin
            failures++; $display("FAIL lat_ob_upd got=%h/%b exp=1/1", a_ob, a_upd);
        end
        tick();                // edge k+3
        checks++;
        if (a_upd !== 1'b0) begin failures++; $display("FAIL lat_upd_drop got=%b exp=0", a_upd); end
    endtask

    task automatic test_full_wrap();
        int upd_cnt = 0;
        int err_seen = 0;
        int bad_ob = 0;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            a_in = gray_tbl[i % 16];
            for (int t = 0; t < 4; t++) begin
                tick();
                if (a_upd === 1'b1) upd_cnt++;
                if (a_err !== 1'b0) err_seen++;
            end
            if (a_ob !== 4'(i % 16)) begin
                bad_ob++;
                $display("FAIL wrap_ob step=%0d got=%h exp=%h", i, a_ob, 4'(i % 16));
            end
        end
        checks++;
        if (bad_ob != 0) failures++;
        checks++;
        if (upd_cnt != 16) begin failures++; $display("FAIL wrap_upd got=%0d exp=16", upd_cnt); end
        checks++;
        if (err_seen != 0 || a_cnt !== 4'h0) begin
            failures++; $display("FAIL wrap_err got=%0d/%h exp=0/0", err_seen, a_cnt);
        end
    endtask

    task automatic test_violation();
        do_reset();
        a_in = 4'h3;
        tick(); tick(); tick();
        checks++;
        if (a_err !== 1'b1 || a_ob !== 4'h2) begin
            failures++; $display("FAIL viol_pulse got=%b/%h exp=1/2", a_err, a_ob);
        end
        tick();
        checks++;
        if (a_err !== 1'b0 || a_stk !== 1'b1 || a_cnt !== 4'h1) begin
            failures++; $display("FAIL viol_book got=%b/%b/%h exp=0/1/1", a_err, a_stk, a_cnt);
        end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        checks++;
        if (a_stk !== 1'b0 || a_cnt !== 4'h0) begin
            failures++; $display("FAIL viol_clr got=%b/%h exp=0/0", a_stk, a_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            e_in = (v % 2 == 1) ? 4'h3 : 4'h0;
            repeat (4) tick();
            if (v == 3) begin
                checks++;
                if (e_cnt !== 2'd3) begin failures++; $display("FAIL sat_three got=%0d exp=3", e_cnt); end
            end
        end
        checks++;
        if (e_cnt !== 2'd3 || e_stk !== 1'b1) begin
            failures++; $display("FAIL sat_hold got=%0d/%b exp=3/1", e_cnt, e_stk);
        end
        // In is now 3; jump back to 0 and clear while err is high
        e_in = 4'h0;
        tick(); tick(); tick();
        checks++;
        if (e_err !== 1'b1) begin failures++; $display("FAIL sat_err got=%b exp=1", e_err); end
        e_clr = 1'b1;
        tick();
        e_clr = 1'b0;
        checks++;
        if (e_cnt !== 2'd1 || e_stk !== 1'b1) begin
            failures++; $display("FAIL sat_clr_coinc got=%0d/%b exp=1/1", e_cnt, e_stk);
        end
    endtask

    task automatic test_stages3_reset();
        do_reset();
        s_in = 4'h1;
        tick(); tick(); tick();    // edges k..k+2
        checks++;
        if (s_og !== 4'h1 || s_ob !== 4'h0) begin
            failures++; $display("FAIL s3_early got=%h/%h exp=1/0", s_og, s_ob);
        end
        tick();                    // edge k+3
        checks++;
        if (s_ob !== 4'h1 || s_upd !== 1'b1) begin
            failures++; $display("FAIL s3_ob_upd got=%h/%b exp=1/1", s_ob, s_upd);
        end
        #2 reset = 1'b1;           // between edges, upd still high
        #1;
        checks++;
        if (s_upd !== 1'b0 || s_ob !== 4'h0 || s_og !== 4'h0) begin
            failures++; $display("FAIL s3_midreset got=%b/%h/%h exp=0/0/0", s_upd, s_ob, s_og);
        end
        s_in = 4'h0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full_wrap();
        test_violation();
        test_saturation();
        test_stages3_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
